sseg_driver: RTL and testbench
==============================

# sseg_driver

Time-multiplexed driver for the 8-digit, common-anode, active-low seven-segment display. It captures a 32-bit value on a load strobe and displays it either as 8 hex nibbles or as 8 decimal digits. Decimal conversion is a sequential shift-add-3 (double-dabble) engine. The driver scans one digit at a time and produces the `segments`/`anodes` pattern that the board display, and the testbench-side segment monitor, consume.

## Interface
- `REFRESH_DIV`, default 4: clock cycles each digit stays lit. Legal range is ≥2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `value`  in  32  number to display. Sampled on an accepted `load`.
- `dec`  in  1  mode, sampled with `value`. 0 = hex nibbles, 1 = decimal.
- `load`  in  1  capture strobe. Accepted only when `busy` = 0.
- `busy`  out  1  high while a decimal conversion is in progress.
- `segments`  out  7  active-low segment pattern: [6]=a, [5]=b, … [0]=g. Registered.
- `anodes`  out  8  active-low digit enable: [i] selects digit i, digit 0 is least significant. Registered, one-hot-low.

## Operation
- **Display register:** 8 × 4-bit digits, `disp[7:0]`. It is the only source for scanning. Reset value is all 0.
- **State machine:** IDLE, CONV.
  - IDLE, `load`=1, `dec`=0:
    - `disp[i]` ← `value[4i+3:4i]` on that edge.
    - Stay in IDLE; `busy` stays 0.
  - IDLE, `load`=1, `dec`=1:
    - Capture `value` into a 32-bit shift register.
    - Clear the 32-bit BCD accumulator and the step counter.
    - Go to CONV.
  - CONV, one step per cycle:
    - Every BCD nibble ≥5 gets +3.
    - Then shift {bcd, bin} left by 1.
  - CONV, after the 32nd step:
    - `disp` ← the low 8 BCD digits, on the same edge as the step.
    - Return to IDLE.
  - Decimal result is `value` mod 100,000,000. Overflow above 99,999,999 is silently truncated to the low 8 digits; no error flag.
  - The BCD accumulator holds only 8 digits (32 bits). Carries out of digit 7 are discarded, which is exactly the mod-10^8 behaviour.
  - `load` in CONV is ignored, with no queueing.
- **Scan:**
  - Refresh counter runs 0…REFRESH_DIV-1 continuously, independent of the state machine.
  - On wrap, the digit index advances 0→1→…→7→0.
- **Output register, updated every cycle:**
  - `anodes` ← ~(8'b1 << idx).
  - `segments` ← enc(`disp[idx]`).
- **enc, active low:**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- `disp` changes mid-scan are shown from the next output-register update; there is no frame synchronisation.

## Timing
- **Reset (edge with `rst_n`=0):**
  - `segments`=7'b1111111, `anodes`=8'hFF (blank), `busy`=0.
  - State IDLE, idx=0, refresh counter=0, `disp`=0.
  - Reset overrides everything, including mid-CONV; a partial conversion is discarded and `disp` returns to 0.
- **First cycle after reset release:** output register loads `anodes`=8'b11111110, `segments`=0000001.
- **Hex load at edge k:** `disp` updated at edge k. Outputs reflect it at edge k+1 if that digit is currently selected.
- **Decimal load at edge k:**
  - `busy`=1 after edge k through edge k+32.
  - `disp` updated at edge k+32; `busy`=0 after edge k+32.
  - Latency is 32 cycles.
  - A new `load` is accepted from edge k+33 onward.
  - If `load` is asserted at edge k+32, it is ignored, because state is still CONV when sampled.
- **Digit dwell:** each anode stays low for exactly REFRESH_DIV cycles. A full frame is 8·REFRESH_DIV cycles.
- **Simultaneous refresh wrap and `disp` update:** the new idx and the new `disp` are both used on the following output update.

## Test plan
- **Reset:** assert `rst_n`=0 for 3 cycles, then release. Required response: `segments`=1111111 and `anodes`=FF during reset. One cycle after release, `anodes`=11111110 and `segments`=0000001. `busy`=0 throughout.
- **Hex load:** load 32'h1234ABCD with `dec`=0 and REFRESH_DIV=4. Over one 32-cycle frame the bench must see:
  - digit 0 = d (1000010), digit 1 = C (0110001), digit 2 = b (1100000), digit 3 = A (0001000)
  - digit 4 = 4, digit 5 = 3, digit 6 = 2, digit 7 = 1
  - each anode low for exactly 4 cycles
  - `busy` never asserts.
- **Decimal load:** load 12345678 with `dec`=1. Required: `busy` high for exactly 32 cycles. Then the frame shows digits 8,7,6,5,4,3,2,1 on anodes 0…7. The segment monitor reads back 12345678.
- **Decimal overflow:** load 32'hFFFFFFFF (4,294,967,295) with `dec`=1. Required: display reads 94967295. Separately, load 0 with `dec`=1; required: display shows all '0'.
- **Load while busy:** load 99 (dec), then load 5 (hex) 10 cycles later. Required: the second load is ignored and the final display is 00000099.
- **Reset mid-conversion:** assert reset during CONV step 15, then release. Required: `busy`=0 and the display is all '0'. A fresh decimal load of 42 then completes 32 cycles later showing 00000042.

Source files
------------

// File: rtl/sseg_driver.sv
// Time-multiplexed driver for an 8-digit active-low seven-segment display.
// Shows a captured 32-bit value as hex nibbles or as double-dabble decimal.
module sseg_driver #(
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value,
    input  logic        dec,
    input  logic        load,
    output logic        busy,
    output logic [6:0]  segments,
    output logic [7:0]  anodes
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t        state;
    logic [CW-1:0] ref_cnt;
    logic [2:0]    idx;
    logic [3:0]    disp [8];
    logic [31:0]   bin;
    logic [31:0]   bcd;
    logic [4:0]    step;
    logic [31:0]   bcd_adj;
    logic [31:0]   bcd_next;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Add-3 on every BCD digit >= 5, then shift; carry out of digit 7 is dropped.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[30:0], bin[31]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ref_cnt  <= '0;
            idx      <= '0;
            bin      <= '0;
            bcd      <= '0;
            step     <= '0;
            segments <= '1;
            anodes   <= '1;
            for (int unsigned i = 0; i < 8; i++)
                disp[i] <= '0;
        end else begin
            if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                idx     <= idx + 3'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            anodes   <= ~(8'b1 << idx);
            segments <= enc(disp[idx]);

            case (state)
                IDLE: begin
                    if (load) begin
                        if (dec) begin
                            bin   <= value;
                            bcd   <= '0;
                            step  <= '0;
                            busy  <= 1'b1;
                            state <= CONV;
                        end else begin
                            for (int unsigned i = 0; i < 8; i++)
                                disp[i] <= value[4*i +: 4];
                        end
                    end
                end
                CONV: begin
                    bcd  <= bcd_next;
                    bin  <= {bin[30:0], 1'b0};
                    step <= step + 5'd1;
                    if (step == 5'd31) begin
                        for (int unsigned i = 0; i < 8; i++)
                            disp[i] <= bcd_next[4*i +: 4];
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_driver.sv
// Scoreboard bench for sseg_driver: expected display words are queued at load
// time and compared against frames decoded from the segment/anode outputs.
module tb_sseg_driver;

    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] value = '0;
    logic        dec = 1'b0;
    logic        load = 1'b0;
    logic        busy;
    logic [6:0]  segments;
    logic [7:0]  anodes;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] sb_q [$];

    sseg_driver #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .dec      (dec),
        .load     (load),
        .busy     (busy),
        .segments (segments),
        .anodes   (anodes)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bench-side decoder of the active-low segment code; bit 4 flags an unknown pattern.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: return 5'h00;
            7'b1001111: return 5'h01;
            7'b0010010: return 5'h02;
            7'b0000110: return 5'h03;
            7'b1001100: return 5'h04;
            7'b0100100: return 5'h05;
            7'b0100000: return 5'h06;
            7'b0001111: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0000100: return 5'h09;
            7'b0001000: return 5'h0A;
            7'b1100000: return 5'h0B;
            7'b0110001: return 5'h0C;
            7'b1000010: return 5'h0D;
            7'b0110000: return 5'h0E;
            7'b0111000: return 5'h0F;
            default:    return 5'h10;
        endcase
    endfunction

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        int unsigned w;
        logic [31:0] r;
        w = v % 32'd100000000;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(w % 10);
            w = w / 10;
        end
        return r;
    endfunction

    task automatic drive_load(input logic [31:0] v, input logic d);
        @(negedge clk);
        value = v;
        dec   = d;
        load  = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic count_busy(input string tag, input int unsigned exp);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(tag, 64'(n), 64'(exp));
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(tag, 64'(n < 200), 64'(1));
    endtask

    // Monitor one full frame, reconstruct the displayed word and pop the scoreboard.
    task automatic capture_frame(input string tag);
        logic [31:0] got;
        logic [31:0] exp;
        logic [4:0]  d;
        int unsigned dwell [8];
        int unsigned onehot_err;
        int unsigned pat_err;
        int unsigned dwell_err;
        int unsigned busy_hi;
        int          sel;
        got = '0;
        onehot_err = 0;
        pat_err = 0;
        dwell_err = 0;
        busy_hi = 0;
        for (int i = 0; i < 8; i++) dwell[i] = 0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < int'(FRAME); c++) begin
            if ($countones(~anodes) != 1) begin
                onehot_err++;
            end else begin
                sel = 0;
                for (int i = 0; i < 8; i++) if (!anodes[i]) sel = i;
                d = decode(segments);
                if (d[4]) pat_err++;
                got[4*sel +: 4] = d[3:0];
                dwell[sel]++;
            end
            if (busy) busy_hi++;
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) if (dwell[i] != DIV) dwell_err++;
        check({tag, "_onehot"}, 64'(onehot_err), 64'(0));
        check({tag, "_pattern"}, 64'(pat_err), 64'(0));
        check({tag, "_dwell"}, 64'(dwell_err), 64'(0));
        check({tag, "_busy_idle"}, 64'(busy_hi), 64'(0));
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_frame"}, 64'(got), 64'(exp));
        end
    endtask

    initial begin
        // Reset held for three cycles.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_segments", 64'(segments), 64'h7F);
        check("rst_anodes", 64'(anodes), 64'hFF);
        check("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_anodes", 64'(anodes), 64'hFE);
        check("rel_segments", 64'(segments), 64'h01);
        check("rel_busy", 64'(busy), 64'(0));

        sb_q.push_back(32'h0);
        capture_frame("reset");

        drive_load(32'h1234ABCD, 1'b0);
        sb_q.push_back(32'h1234ABCD);
        capture_frame("hex");

        drive_load(32'd12345678, 1'b1);
        sb_q.push_back(to_bcd(32'd12345678));
        count_busy("dec_busy_len", 32);
        capture_frame("dec");

        drive_load(32'hFFFFFFFF, 1'b1);
        sb_q.push_back(to_bcd(32'hFFFFFFFF));
        count_busy("ovf_busy_len", 32);
        capture_frame("ovf");

        drive_load(32'd0, 1'b1);
        sb_q.push_back(to_bcd(32'd0));
        count_busy("zero_busy_len", 32);
        capture_frame("zero");

        // A hex load issued mid-conversion must be dropped.
        drive_load(32'd99, 1'b1);
        sb_q.push_back(to_bcd(32'd99));
        repeat (9) @(posedge clk);
        drive_load(32'd5, 1'b0);
        @(negedge clk);
        wait_idle("busy_timeout");
        capture_frame("ignore");

        // Reset during conversion step 15 discards everything.
        drive_load(32'd12345678, 1'b1);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_anodes", 64'(anodes), 64'hFF);
        rst_n = 1'b1;
        sb_q.push_back(32'h0);
        capture_frame("midrst");

        drive_load(32'd42, 1'b1);
        sb_q.push_back(to_bcd(32'd42));
        count_busy("post_busy_len", 32);
        capture_frame("post");

        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
